// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bundle of the register-file read arbiter: request/address in,
// grant plus tagged read result out. The master is the requester side, the slave is the arbiter.
interface regfile_read_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  // Handshake: req[i] is held with addr[i*AW +: AW] stable until gnt[i] is seen.
  // A transfer happens on the rising edge where req[i] & gnt[i]. rvalid[i] is a
  // single-cycle pulse two edges later and marks rdata as belonging to requester i.
  // There is no back-pressure on the result path. en=0 blocks new grants only.
  logic [N_REQ-1:0]    req;
  logic [N_REQ*AW-1:0] addr;
  logic                en;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       rdata;
  logic [N_REQ-1:0]    rvalid;

  modport master (
    output req,
    output addr,
    output en,
    input  gnt,
    input  rdata,
    input  rvalid
  );

  modport slave (
    input  req,
    input  addr,
    input  en,
    output gnt,
    output rdata,
    output rvalid
  );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin sharing of the register bank's single read port. It registers the address
// to the bank and returns registered, owner-tagged read data.
// Optional same-cycle write forwarding is enabled by defining RFARB_WRITE_BYPASS_EN.
module regfile_read_arbiter #(
  parameter int N_REQ = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_read_arbiter_if.slave rq,
  output logic [AW-1:0]         rf_ra,
  input  logic [DW-1:0]         rf_rd
`ifdef RFARB_WRITE_BYPASS_EN
  ,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [DW-1:0]         wd
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Arbitration and pipeline state
  logic [PW-1:0]    ptr_q;
  logic             s1_v;
  logic [PW-1:0]    s1_owner;
  logic [DW-1:0]    rdata_q;
  logic [N_REQ-1:0] rvalid_q;

  // Per-requester address view
  logic [AW-1:0] addr_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign addr_arr[g] = rq.addr[g*AW +: AW];
  end

  // Round-robin search starting at ptr_q
  logic [PW:0]      cand;
  logic [PW-1:0]    win_idx;
  logic             win_v;
  logic [N_REQ-1:0] gnt_c;

  always_comb begin
    cand    = '0;
    win_idx = '0;
    win_v   = 1'b0;
    gnt_c   = '0;
    if (!reset && rq.en) begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = {1'b0, ptr_q} + (PW+1)'(k);
        if (cand >= (PW+1)'(N_REQ)) begin
          cand = cand - (PW+1)'(N_REQ);
        end
        if (!win_v && rq.req[cand[PW-1:0]]) begin
          win_v   = 1'b1;
          win_idx = cand[PW-1:0];
        end
      end
      if (win_v) begin
        gnt_c[win_idx] = 1'b1;
      end
    end
  end

  assign rq.gnt = gnt_c;

  // The grant is only asserted toward a requesting index, so a grant is the accept.
  logic          accept;
  logic [PW-1:0] ptr_nxt;

  assign accept  = win_v;
  assign ptr_nxt = (win_idx == PW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // Read data selection at the capture edge; register 0 is hard-wired to zero
  logic [DW-1:0] rd_sel;

  always_comb begin
    rd_sel = rf_rd;
`ifdef RFARB_WRITE_BYPASS_EN
    if (we && (wa == rf_ra)) begin
      rd_sel = wd;
    end
`endif
    if (rf_ra == '0) begin
      rd_sel = '0;
    end
  end

  logic [N_REQ-1:0] owner_onehot;

  always_comb begin
    owner_onehot           = '0;
    owner_onehot[s1_owner] = 1'b1;
  end

  // Stage 1: accept and address register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q    <= '0;
      rf_ra    <= '0;
      s1_v     <= 1'b0;
      s1_owner <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        rf_ra    <= addr_arr[win_idx];
        s1_owner <= win_idx;
        ptr_q    <= ptr_nxt;
      end
    end
  end

  // Stage 2: read capture and owner tag
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      if (s1_v) begin
        rdata_q  <= rd_sel;
        rvalid_q <= owner_onehot;
      end else begin
        rvalid_q <= '0;
      end
    end
  end

  assign rq.rdata  = rdata_q;
  assign rq.rvalid = rvalid_q;

endmodule
